wdf_alloc: RTL
==============

# wdf_alloc

Slot allocator that sits directly upstream of the write data FIFO (WDF) in the memory controller. It accepts host write bursts over a valid/ready handshake and picks a free WDF slot for each one. It writes the data into that slot and hands the slot id to the command scheduler in allocation order. It returns slots to the free pool when the read side reports them drained to DFI.

## Interface
- `SLOTS`, 8, number of WDF slots (power of two)
- `PTR_W`, 3, slot id width, log2(SLOTS)
- `DATA_W`, 64, write data width
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: reset, synchronous, active-high
- `host_valid` in 1: host write data valid
- `host_data` in DATA_W: host write data
- `host_ready` out 1: allocator can accept this cycle
- `wdf_wr` out 1: write strobe to WDF
- `wdf_wptr` out PTR_W: WDF slot being written
- `wdf_data` out DATA_W: data to WDF
- `wdf_wr_p` out 1: parity of `wdf_data`; see Configuration
- `cmd_valid` out 1: allocated slot id available to scheduler
- `cmd_slot` out PTR_W: oldest allocated, unconsumed slot id
- `cmd_ready` in 1: scheduler consumes `cmd_slot`
- `rel_valid` in 1: slot drained from WDF, free it
- `rel_slot` in PTR_W: slot being released
- `free_cnt` out PTR_W+1: number of free slots
- `err` out 1: sticky, release of a slot that is already free

## Operation
- State:
  - free bitmap `free[SLOTS-1:0]`
  - in-order slot id FIFO, depth SLOTS
  - registered WDF write stage
- `host_ready = !rst && free != 0`.
- Accept when `host_valid && host_ready`.
  - Allocated slot is the lowest-index set bit of `free`.
  - The bit is cleared and the slot id is pushed into the id FIFO.
  - `host_data` and the slot are captured into the write stage.
- Write stage:
  - `wdf_wr` is 1 for exactly one cycle per accept.
  - `wdf_wptr` and `wdf_data` hold the captured values in that cycle.
  - Outside that cycle `wdf_wr` is 0, and `wdf_wptr`/`wdf_data` hold their last values.
- Command side:
  - `cmd_valid = FIFO not empty`.
  - `cmd_slot` = FIFO head.
  - Pop on `cmd_valid && cmd_ready`.
  - `cmd_ready` while empty is ignored.
- Release:
  - `rel_valid` with `free[rel_slot]==0` sets `free[rel_slot]`.
  - `rel_valid` with `free[rel_slot]==1` sets `err`; the bitmap is unchanged.
- No same-cycle bypass: a released slot becomes allocatable the following cycle.
- Allocate and release in the same cycle both apply; they are always different slots. `free_cnt` changes by 0 net.
- Id FIFO can never overflow: there are at most SLOTS allocated slots, so at most SLOTS FIFO entries.
- `err` clears only on `rst`.

## Timing
- Reset values:
  - `wdf_wr`=0, `wdf_wptr`=0, `wdf_data`=0, `wdf_wr_p`=0
  - `cmd_valid`=0, `cmd_slot`=0
  - `free_cnt`=SLOTS, `err`=0
  - `host_ready`=0 while `rst`=1, 1 the first cycle after
- Accept at edge N → `wdf_wr`=1 in cycle N+1.
- Accept at edge N → `cmd_valid`=1 with that id in cycle N+1 at the earliest (FIFO registered). The WDF write completes at edge N+1, before any read the scheduler can issue.
- `free_cnt` reflects the accept/release of edge N in cycle N+1.
- Sustained throughput is one accept per cycle while slots are free.
- Full: after SLOTS accepts with no release, `host_ready`=0 and `free_cnt`=0.
- Reset mid-operation:
  - all slots become free and the id FIFO is emptied
  - a pending `wdf_wr` is dropped
  - `err` clears

## Configuration
- `WDF_ALLOC_PARITY_EN` defined: `wdf_wr_p` = XOR-reduce of `wdf_data`, registered with the write stage.
- Undefined: `wdf_wr_p` tied 0 and no parity logic is built.

## Structure
- Package `wdf_pkg`:
  - `SLOTS`, `PTR_W`, `DATA_W` constants
  - `typedef logic [PTR_W-1:0] slot_t`
  - `typedef logic [DATA_W-1:0] wdata_t`
- Shared with the WDF and the scheduler.
- One sub-module, `wdf_id_fifo`: synchronous FIFO of `slot_t`, depth SLOTS, with count.
- Free bitmap, priority encoder and write stage live in the top module.

## Test plan
- Reset, then one accept with `host_data`=0xDEADBEEF → cycle N+1: `wdf_wr`=1, `wdf_wptr`=0, `wdf_data`=0xDEADBEEF, `cmd_valid`=1, `cmd_slot`=0, `free_cnt`=7. Parity build: `wdf_wr_p`=0.
- 8 back-to-back accepts → slots 0..7 in order, `host_ready`=0, `free_cnt`=0. A 9th `host_valid` is held off; `cmd_slot` pops 0..7 in order.
- Full, release slot 5 → next cycle `host_ready`=1. Next accept gets slot 5, `free_cnt` returns to 0.
- Release slot 2 and accept in the same cycle with slots 2,3 allocated and 4 lowest free → accept gets 4, slot 2 is free afterwards, `free_cnt` unchanged.
- Release slot 6 while it is already free → `err`=1 and stays 1, `free_cnt` unchanged; `rst` clears `err`.
- Assert `rst` with 3 slots allocated and `wdf_wr` pending → next cycle `free_cnt`=8, `cmd_valid`=0, `wdf_wr`=0.

Source files
------------

// File: rtl/wdf_pkg.sv
// Shared WDF definitions: slot count, widths and the slot/data types used by
// the allocator, the write data FIFO and the command scheduler.
package wdf_pkg;

  localparam int SLOTS  = 8;
  localparam int PTR_W  = 3;
  localparam int DATA_W = 64;

  typedef logic [PTR_W-1:0]  slot_t;
  typedef logic [DATA_W-1:0] wdata_t;
  typedef logic [PTR_W:0]    cnt_t;

  function automatic cnt_t popcount(input logic [SLOTS-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < SLOTS; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/wdf_id_fifo.sv
// In-order FIFO of allocated slot ids, depth SLOTS, with occupancy count.
module wdf_id_fifo
  import wdf_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  slot_t push_slot,
  input  logic  pop,
  output slot_t head,
  output cnt_t  count
);

  slot_t mem [SLOTS];
  slot_t wr_ptr;
  slot_t rd_ptr;
  cnt_t  cnt;
  logic  do_pop;

  // Pops on an empty FIFO are dropped; pushes can never find it full.
  assign do_pop = pop && (cnt != '0);
  assign head   = mem[rd_ptr];
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_slot;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + cnt_t'(push) - cnt_t'(do_pop);
    end
  end

endmodule

// File: rtl/wdf_alloc.sv
// WDF slot allocator: lowest-free-slot allocation, registered WDF write stage,
// in-order id hand-off to the scheduler. Option: WDF_ALLOC_PARITY_EN.
module wdf_alloc
  import wdf_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   host_valid,
  input  wdata_t host_data,
  output logic   host_ready,
  output logic   wdf_wr,
  output slot_t  wdf_wptr,
  output wdata_t wdf_data,
  output logic   wdf_wr_p,
  output logic   cmd_valid,
  output slot_t  cmd_slot,
  input  logic   cmd_ready,
  input  logic   rel_valid,
  input  slot_t  rel_slot,
  output cnt_t   free_cnt,
  output logic   err
);

  logic [SLOTS-1:0] free_map;
  logic [SLOTS-1:0] free_next;
  slot_t            alloc_slot;
  logic             accept;
  logic             rel_ok;
  cnt_t             fifo_count;

  assign host_ready = !rst && (free_map != '0);
  assign accept     = host_valid && host_ready;
  assign rel_ok     = rel_valid && !free_map[rel_slot];
  assign free_cnt   = popcount(free_map);
  assign cmd_valid  = (fifo_count != '0);

  // Scanning downward leaves the lowest set bit as the final winner.
  always_comb begin
    alloc_slot = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free_map[i]) alloc_slot = slot_t'(i);
    end
  end

  // Release works on the pre-edge bitmap, so a freed slot is not allocatable
  // until the following cycle.
  always_comb begin
    free_next = free_map;
    if (accept) free_next[alloc_slot] = 1'b0;
    if (rel_ok) free_next[rel_slot]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map <= '1;
      err      <= 1'b0;
    end else begin
      free_map <= free_next;
      if (rel_valid && free_map[rel_slot]) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdf_wr   <= 1'b0;
      wdf_wptr <= '0;
      wdf_data <= '0;
    end else begin
      wdf_wr <= accept;
      if (accept) begin
        wdf_wptr <= alloc_slot;
        wdf_data <= host_data;
      end
    end
  end

`ifdef WDF_ALLOC_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdf_wr_p <= 1'b0;
    end else if (accept) begin
      wdf_wr_p <= ^host_data;
    end
  end
`else
  assign wdf_wr_p = 1'b0;
`endif

  wdf_id_fifo u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_slot (alloc_slot),
    .pop       (cmd_ready),
    .head      (cmd_slot),
    .count     (fifo_count)
  );

endmodule
